// File: rtl/wb_bus_arbiter.sv
// Registered two-master Wishbone arbiter in front of the core memory slave.
// Master 0 is the interpreter and master 1 is the core. Round-robin on ties, interpreter lock, per-transfer ack timeout.
//
// state | meaning
// IDLE  | no grant, arbitration decision registered for next cycle
// GNT0  | interpreter (m0) owns the slave
// GNT1  | core (m1) owns the slave
// ABORT | one-cycle abort of a timed-out transfer, err to the owner
module wb_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lock_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    // The abort fires on the stalled cycle that would bring the count up to TIMEOUT_CYCLES.
    localparam logic [TIMEOUT_BITS-1:0] TMO_LAST =
        (TIMEOUT_CYCLES > 0) ? TIMEOUT_BITS'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);

    state_t                  state;
    state_t                  state_next;
    logic                    last_grant;
    logic [TIMEOUT_BITS-1:0] tmo_cnt;
    logic [TIMEOUT_BITS-1:0] tmo_cnt_next;
    logic                    req0;
    logic                    req1;
    logic                    granted;
    logic                    stalled;
    logic                    tmo_hit;

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i & ~lock_i;
    assign granted = (state == ST_GNT0) || (state == ST_GNT1);
    assign stalled = granted & s_stb_o & ~s_ack_i;
    assign tmo_hit = TMO_EN & stalled & (tmo_cnt == TMO_LAST);

    assign tmo_cnt_next = (stalled && (state_next == state))
                          ? tmo_cnt + TIMEOUT_BITS'(1) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            tmo_cnt    <= '0;
            timeout_o  <= 1'b0;
        end else begin
            if (state_next == ST_GNT0) begin
                last_grant <= 1'b0;
            end else if (state_next == ST_GNT1) begin
                last_grant <= 1'b1;
            end
            tmo_cnt <= tmo_cnt_next;
            if (state_next == ST_ABORT) begin
                timeout_o <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_next = last_grant ? ST_GNT0 : ST_GNT1;
                end else if (req0) begin
                    state_next = ST_GNT0;
                end else if (req1) begin
                    state_next = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (tmo_hit) begin
                    state_next = ST_ABORT;
                end else if (!m0_cyc_i) begin
                    state_next = req1 ? ST_GNT1 : ST_IDLE;
                end
            end
            // lock only gates new m1 grants; an m1 cycle in flight runs to completion
            ST_GNT1: begin
                if (tmo_hit) begin
                    state_next = ST_ABORT;
                end else if (!m1_cyc_i) begin
                    state_next = req0 ? ST_GNT0 : ST_IDLE;
                end
            end
            ST_ABORT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_data_o  = '0;
        m0_data_o = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        grant_o   = 2'b00;
        case (state)
            ST_GNT0: begin
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i;
                s_we_o    = m0_we_i;
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                m0_ack_o  = s_ack_i;
                m0_data_o = s_data_i;
                grant_o   = 2'b01;
            end
            ST_GNT1: begin
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i;
                s_we_o    = m1_we_i;
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                m1_ack_o  = s_ack_i;
                m1_data_o = s_data_i;
                grant_o   = 2'b10;
            end
            // last_grant still names the master whose transfer was aborted
            ST_ABORT: begin
                m0_err_o = ~last_grant;
                m1_err_o = last_grant;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: per-cycle vector table plus hand sequences
// for async reset, lock behaviour and lock-without-preemption.
module tb_wb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] A0 = 32'h0000_0010;
    localparam logic [31:0] A1 = 32'h0000_0020;

    logic          clk;
    logic          rst;
    logic          lock;
    logic          m0_cyc, m0_stb, m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m0_ack, m0_err;
    logic          m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic          s_ack;
    logic [1:0]    grant;
    logic          timeout;

    int errors = 0;
    int checks = 0;

    wb_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4), .TIMEOUT_BITS(8)
    ) dut (
        .clk(clk), .rst(rst), .lock_i(lock),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_data_i(m0_wdata), .m0_data_o(m0_rdata), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_data_i(m1_wdata), .m1_data_o(m1_rdata), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr),
        .s_data_o(s_wdata), .s_data_i(s_rdata), .s_ack_i(s_ack),
        .grant_o(grant), .timeout_o(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, lock, c0, c1, ack;
        logic [31:0] a0, a1, sd;
        logic [1:0]  g;
        logic        sc, swe, k0, k1, e0, e1, t;
        logic [31:0] sa, d0, d1;
    } vec_t;

    vec_t tbl[36];

    function automatic vec_t mk(
        input logic r, input logic lk, input logic c0, input logic [31:0] a0,
        input logic c1, input logic [31:0] a1, input logic ack, input logic [31:0] sd,
        input logic [1:0] g, input logic sc, input logic [31:0] sa, input logic swe,
        input logic k0, input logic k1, input logic [31:0] d0, input logic [31:0] d1,
        input logic e0, input logic e1, input logic t);
        vec_t v;
        v.rst = r; v.lock = lk; v.c0 = c0; v.a0 = a0; v.c1 = c1; v.a1 = a1;
        v.ack = ack; v.sd = sd; v.g = g; v.sc = sc; v.sa = sa; v.swe = swe;
        v.k0 = k0; v.k1 = k1; v.d0 = d0; v.d1 = d1; v.e0 = e0; v.e1 = e1; v.t = t;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        rst = v.rst; lock = v.lock;
        m0_cyc = v.c0; m0_stb = v.c0; m0_addr = v.a0;
        m1_cyc = v.c1; m1_stb = v.c1; m1_addr = v.a1;
        s_ack = v.ack; s_rdata = v.sd;
        @(negedge clk);
        chk("grant",   idx, 32'(grant),   32'(v.g));
        chk("s_cyc",   idx, 32'(s_cyc),   32'(v.sc));
        chk("s_stb",   idx, 32'(s_stb),   32'(v.sc));
        chk("s_addr",  idx, s_addr,       v.sa);
        chk("s_we",    idx, 32'(s_we),    32'(v.swe));
        chk("m0_ack",  idx, 32'(m0_ack),  32'(v.k0));
        chk("m1_ack",  idx, 32'(m1_ack),  32'(v.k1));
        chk("m0_data", idx, m0_rdata,     v.d0);
        chk("m1_data", idx, m1_rdata,     v.d1);
        chk("m0_err",  idx, 32'(m0_err),  32'(v.e0));
        chk("m1_err",  idx, 32'(m1_err),  32'(v.e1));
        chk("timeout", idx, 32'(timeout), 32'(v.t));
        step();
    endtask

    initial begin
        rst = 1'b1; lock = 1'b0;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = 32'hA0A0_A0A0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b1; m1_addr = '0; m1_wdata = 32'hB1B1_B1B1;
        s_ack = 1'b0; s_rdata = '0;

        // single m0 read, slave acks on the second granted cycle
        tbl[0]  = mk(1,0, 0,0,  0,0,  0,0,            2'b00,0,0,0,  0,0,0,0,            0,0,0);
        tbl[1]  = mk(0,0, 1,A0, 0,0,  0,0,            2'b00,0,0,0,  0,0,0,0,            0,0,0);
        tbl[2]  = mk(0,0, 1,A0, 0,0,  0,0,            2'b01,1,A0,0, 0,0,0,0,            0,0,0);
        tbl[3]  = mk(0,0, 1,A0, 0,0,  1,32'hDEADBEEF, 2'b01,1,A0,0, 1,0,32'hDEADBEEF,0, 0,0,0);
        tbl[4]  = mk(0,0, 0,0,  0,0,  0,0,            2'b01,0,0,0,  0,0,0,0,            0,0,0);
        tbl[5]  = mk(0,0, 0,0,  0,0,  0,0,            2'b00,0,0,0,  0,0,0,0,            0,0,0);
        // reset, then four simultaneous requests alternating m0,m1,m0,m1
        tbl[6]  = mk(1,0, 0,0,  0,0,  0,0,            2'b00,0,0,0,  0,0,0,0,            0,0,0);
        tbl[7]  = mk(0,0, 1,A0, 1,A1, 1,32'h55550000, 2'b00,0,0,0,  0,0,0,0,            0,0,0);
        tbl[8]  = mk(0,0, 1,A0, 1,A1, 1,32'h11110001, 2'b01,1,A0,0, 1,0,32'h11110001,0, 0,0,0);
        tbl[9]  = mk(0,0, 0,0,  0,0,  0,0,            2'b01,0,0,0,  0,0,0,0,            0,0,0);
        tbl[10] = mk(0,0, 1,A0, 1,A1, 0,0,            2'b00,0,0,0,  0,0,0,0,            0,0,0);
        tbl[11] = mk(0,0, 1,A0, 1,A1, 1,32'h22220002, 2'b10,1,A1,1, 0,1,0,32'h22220002, 0,0,0);
        tbl[12] = mk(0,0, 0,0,  0,0,  0,0,            2'b10,0,0,1,  0,0,0,0,            0,0,0);
        tbl[13] = mk(0,0, 1,A0, 1,A1, 0,0,            2'b00,0,0,0,  0,0,0,0,            0,0,0);
        tbl[14] = mk(0,0, 1,A0, 1,A1, 1,32'h33330003, 2'b01,1,A0,0, 1,0,32'h33330003,0, 0,0,0);
        tbl[15] = mk(0,0, 0,0,  0,0,  0,0,            2'b01,0,0,0,  0,0,0,0,            0,0,0);
        tbl[16] = mk(0,0, 1,A0, 1,A1, 0,0,            2'b00,0,0,0,  0,0,0,0,            0,0,0);
        tbl[17] = mk(0,0, 1,A0, 1,A1, 1,32'h44440004, 2'b10,1,A1,1, 0,1,0,32'h44440004, 0,0,0);
        tbl[18] = mk(0,0, 0,0,  0,0,  0,0,            2'b10,0,0,1,  0,0,0,0,            0,0,0);
        // ack lands on the stall that would otherwise trigger the abort
        tbl[19] = mk(0,0, 1,A0, 0,0,  0,0,            2'b00,0,0,0,  0,0,0,0,            0,0,0);
        tbl[20] = mk(0,0, 1,A0, 0,0,  0,0,            2'b01,1,A0,0, 0,0,0,0,            0,0,0);
        tbl[21] = mk(0,0, 1,A0, 0,0,  0,0,            2'b01,1,A0,0, 0,0,0,0,            0,0,0);
        tbl[22] = mk(0,0, 1,A0, 0,0,  0,0,            2'b01,1,A0,0, 0,0,0,0,            0,0,0);
        tbl[23] = mk(0,0, 1,A0, 0,0,  1,32'hCAFEF00D, 2'b01,1,A0,0, 1,0,32'hCAFEF00D,0, 0,0,0);
        tbl[24] = mk(0,0, 0,0,  0,0,  0,0,            2'b01,0,0,0,  0,0,0,0,            0,0,0);
        tbl[25] = mk(0,0, 0,0,  0,0,  0,0,            2'b00,0,0,0,  0,0,0,0,            0,0,0);
        // m1 stalls four cycles, abort, then m0 wins the tie
        tbl[26] = mk(0,0, 0,0,  1,A1, 0,0,            2'b00,0,0,0,  0,0,0,0,            0,0,0);
        tbl[27] = mk(0,0, 0,0,  1,A1, 0,0,            2'b10,1,A1,1, 0,0,0,0,            0,0,0);
        tbl[28] = mk(0,0, 0,0,  1,A1, 0,0,            2'b10,1,A1,1, 0,0,0,0,            0,0,0);
        tbl[29] = mk(0,0, 0,0,  1,A1, 0,0,            2'b10,1,A1,1, 0,0,0,0,            0,0,0);
        tbl[30] = mk(0,0, 0,0,  1,A1, 0,0,            2'b10,1,A1,1, 0,0,0,0,            0,0,0);
        tbl[31] = mk(0,0, 1,A0, 1,A1, 0,0,            2'b00,0,0,0,  0,0,0,0,            0,1,1);
        tbl[32] = mk(0,0, 1,A0, 1,A1, 0,0,            2'b00,0,0,0,  0,0,0,0,            0,0,1);
        tbl[33] = mk(0,0, 1,A0, 1,A1, 1,32'h55550005, 2'b01,1,A0,0, 1,0,32'h55550005,0, 0,0,1);
        tbl[34] = mk(0,0, 0,0,  0,0,  0,0,            2'b01,0,0,0,  0,0,0,0,            0,0,1);
        tbl[35] = mk(0,0, 0,0,  0,0,  0,0,            2'b00,0,0,0,  0,0,0,0,            0,0,1);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 36; i++) begin
            run_vec(tbl[i], i);
        end

        // async reset in the middle of a granted m0 transfer
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = A0;
        s_ack = 1'b1; s_rdata = 32'h6666_0006;
        step();
        chk("rst_pre_grant", 0, 32'(grant), 32'(2'b01));
        chk("rst_pre_scyc",  0, 32'(s_cyc), 32'd1);
        chk("rst_pre_ack",   0, 32'(m0_ack), 32'd1);
        chk("rst_pre_tmo",   0, 32'(timeout), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_scyc",  0, 32'(s_cyc), 32'd0);
        chk("rst_grant", 0, 32'(grant), 32'd0);
        chk("rst_ack",   0, 32'(m0_ack), 32'd0);
        chk("rst_data",  0, m0_rdata, 32'd0);
        chk("rst_tmo",   0, 32'(timeout), 32'd0);
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = A1; s_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rel_grant", 0, 32'(grant), 32'd0);
        step();
        chk("rst_tie_grant", 0, 32'(grant), 32'(2'b01));
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
        chk("rst_idle_grant", 0, 32'(grant), 32'd0);

        // lock blocks a lone m1 request
        lock = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = A1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("lock_grant", i, 32'(grant), 32'd0);
            chk("lock_scyc",  i, 32'(s_cyc), 32'd0);
        end
        lock = 1'b0;
        #1;
        chk("unlock_grant_now", 0, 32'(grant), 32'd0);
        step();
        chk("unlock_grant", 0, 32'(grant), 32'(2'b10));
        chk("unlock_scyc",  0, 32'(s_cyc), 32'd1);

        // lock rising while m1 owns the bus does not preempt it
        lock = 1'b1; m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = A0;
        s_ack = 1'b1; s_rdata = 32'h7777_0007;
        step();
        chk("nopre_grant0", 0, 32'(grant), 32'(2'b10));
        chk("nopre_m1ack",  0, 32'(m1_ack), 32'd1);
        chk("nopre_m0ack",  0, 32'(m0_ack), 32'd0);
        chk("nopre_m0data", 0, m0_rdata, 32'd0);
        step();
        chk("nopre_grant1", 0, 32'(grant), 32'(2'b10));
        m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
        step();
        chk("nopre_handover", 0, 32'(grant), 32'(2'b01));
        chk("nopre_addr",     0, s_addr, A0);
        lock = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        chk("final_grant", 0, 32'(grant), 32'd0);
        chk("final_tmo",   0, 32'(timeout), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
